mcycle_sequencer: RTL and testbench
===================================

Name: mcycle_sequencer

Overview:
- Instruction fetch/timing sequencer directly upstream of the CPU register file.
- Divides clk into T-states and M-cycles and latches opcodes from the data bus.
- Decodes a minimal 8-bit load subset and drives the register file controls: m1t1, writeback, inc_pc, wr_sel, rd_sel, wr_en, rd_en, drive_addr, data_in.
- Also drives the external memory read/write strobes.

Parameters:
- T_PER_M, 4, T-states per M-cycle (min 3); T-counter width = $clog2(T_PER_M).

Ports:
- clk, in, 1, system clock (one clock domain).
- rst, in, 1, asynchronous active-low reset.
- mem_rdata, in, 8, external data bus read value.
- mem_wait, in, 1, memory not ready; stalls T-counter at T2.
- rf_rdata, in, 8, register file data_out.
- m1t1, out, 1, high for T1 of every opcode-fetch M-cycle.
- writeback, out, 1, register file write strobe (rising edge commits).
- inc_pc, out, 1, PC increment strobe for immediate-operand fetch.
- wr_sel, out, 3, destination register code (A=111, B=000 … L=101).
- rd_sel, out, 3, source register code, or address select when drive_addr=1.
- wr_en, out, 1, register write enable.
- rd_en, out, 1, register read enable.
- drive_addr, out, 1, address bus source = rd_sel pair instead of PC.
- rf_wdata, out, 8, register file data_in.
- mem_rd, out, 1, memory read strobe.
- mem_wr, out, 1, memory write strobe.
- mem_wdata, out, 8, memory write data.
- halted, out, 1, core halted.

Behaviour:
- Reset: all outputs 0, state FETCH, T=T1, opcode register 0x00. First m1t1 occurs the first clk after rst deasserts.
- T-counter runs T1..T_PER_M and wraps to T1. At T2, if mem_wait=1 and mem_rd or mem_wr is asserted, the counter holds. All outputs hold during the stall.
- FETCH (M1):
  - T1: m1t1=1.
  - T1–T2: mem_rd=1.
  - Opcode is latched from mem_rdata on the T3 edge.
  - Decode takes effect at the last T of M1.
- Decoded subset:
  - 0x00 NOP: 1 M-cycle.
  - LD r,r' (0x40–0x7F, excluding (HL) forms and 0x76): 1 M-cycle. rd_en=1 and rd_sel=src from T3; rf_wdata=rf_rdata; wr_sel=dst; wr_en=1; writeback pulses at the last T.
  - LD r,d8 (0x06/0E/16/1E/26/2E/3E): 2 M-cycles. State OPERAND: mem_rd at T1–T2, data latched at T3, inc_pc pulses at T3. At the last T: rf_wdata=latched data, writeback pulses.
  - LD r,(HL) (0x46/4E/…/7E): 2 M-cycles. State MEMRD: drive_addr=1, rd_sel=110 during T1–T3, mem_rd at T1–T2. The value is then written to r as for d8.
  - LD (HL),r (0x70–0x75, 0x77): 2 M-cycles. State MEMWR: drive_addr=1 with rd_sel=110 for the address. Data is captured into mem_wdata from rf_rdata at T1 (rd_sel=src during M1 last T). mem_wr is asserted at T2–T3.
  - 0x76 HALT: state HALT. halted=1, no strobes, no m1t1. Only reset exits HALT.
- wr_en is 0 whenever writeback is 0. writeback is a single-clk pulse. wr_en and rd_en are never asserted in HALT.
- After the final M-cycle, the next state is FETCH with T=T1.
- Opcodes outside the subset are treated as NOP (1 M-cycle).
- Reset mid-instruction aborts immediately to the reset state. No partial writeback is issued.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit).
  - An undecoded opcode sets illegal_op=1 (sticky until reset) and enters HALT.
- Undefined:
  - No illegal_op port.
  - Undecoded opcodes execute as NOP.

Decomposition:
- Shared package/include gb_cpu_pkg holds:
  - register codes REG_A..REG_L, ADDR_HL=3'b110;
  - state encodings FETCH/OPERAND/MEMRD/MEMWR/HALT;
  - opcode constants.
- One sub-module, mcycle_tcounter: T-state counter with wait-stall, outputs t_idx and last_t.

Test Plan:
- Release reset, mem_rdata=0x00 constant → m1t1 on clk 0, 4, 8, …; no writeback; halted=0.
- Fetch 0x78 (LD A,B) with rf_rdata=0x5A → in that M-cycle rd_sel=000, wr_sel=111, wr_en=1, rf_wdata=0x5A, one writeback pulse at T4.
- Fetch 0x3E then mem_rdata=0xC3 → 8 clks total, one inc_pc pulse at T3 of M2, writeback with rf_wdata=0xC3, wr_sel=111.
- Fetch 0x70 (LD (HL),B) with rf_rdata=0x11 → M2 has drive_addr=1, rd_sel=110, mem_wr=1 at T2–T3, mem_wdata=0x11, no writeback.
- Hold mem_wait=1 for 3 clks during M1 T2 → M-cycle lasts 7 clks; outputs stable during the stall.
- Fetch 0x76 → halted=1, m1t1 never reasserts. Assert rst mid-HALT → all outputs 0; next m1t1 occurs after release.

Source files
------------

// File: rtl/gb_cpu_pkg.sv
// gb_cpu_pkg: register codes, sequencer state encodings, opcode constants
// and the load-subset decoder shared by the M-cycle sequencer.
package gb_cpu_pkg;

  localparam logic [2:0] REG_B   = 3'b000;
  localparam logic [2:0] REG_C   = 3'b001;
  localparam logic [2:0] REG_D   = 3'b010;
  localparam logic [2:0] REG_E   = 3'b011;
  localparam logic [2:0] REG_H   = 3'b100;
  localparam logic [2:0] REG_L   = 3'b101;
  localparam logic [2:0] ADDR_HL = 3'b110;
  localparam logic [2:0] REG_A   = 3'b111;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_OPERAND = 3'd1;
  localparam logic [2:0] ST_MEMRD   = 3'd2;
  localparam logic [2:0] ST_MEMWR   = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h76;
  localparam logic [7:0] OP_LDHN = 8'h36;

  typedef struct packed {
    logic ld_rr;
    logic ld_d8;
    logic ld_r_hl;
    logic ld_hl_r;
    logic halt;
    logic legal;
  } dec_t;

  // Quadrant 01 is the LD r,r' block; (HL) in either
  // field turns it into a memory form, 0x76 is HALT.
  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '0;
    if (op[7:6] == 2'b01) begin
      if (op == OP_HALT)
        d.halt = 1'b1;
      else if (op[2:0] == ADDR_HL)
        d.ld_r_hl = 1'b1;
      else if (op[5:3] == ADDR_HL)
        d.ld_hl_r = 1'b1;
      else
        d.ld_rr = 1'b1;
    end else if (op[7:6] == 2'b00 &&
                 op[2:0] == 3'b110 &&
                 op != OP_LDHN) begin
      d.ld_d8 = 1'b1;
    end
    d.legal = d.ld_rr | d.ld_d8 | d.ld_r_hl |
              d.ld_hl_r | d.halt | (op == OP_NOP);
    return d;
  endfunction

endpackage

// File: rtl/mcycle_tcounter.sv
// mcycle_tcounter: T-state counter (T1 = index 0) that wraps every
// T_PER_M clocks and holds at T2 while mem_wait stalls a busy bus.
// Ports: clk, rst (async, active low), en, mem_wait, busy ->
//        t_idx, last_t, step (counter advances this clock).
module mcycle_tcounter #(
  parameter int T_PER_M = 4,
  parameter int TW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mem_wait,
  input  logic          busy,
  output logic [TW-1:0] t_idx,
  output logic          last_t,
  output logic          step
);

  logic stall;

  assign stall  = (t_idx == TW'(1)) &&
                  mem_wait && busy;
  assign step   = en && !stall;
  assign last_t = (t_idx == TW'(T_PER_M - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_idx <= '0;
    end else if (step) begin
      t_idx <= last_t ? '0 : t_idx + TW'(1);
    end
  end

endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: splits clk into T-states/M-cycles, fetches opcodes,
// runs the 8-bit load subset and drives register-file and memory strobes.
// Inputs: clk, rst (async, active low), mem_rdata, mem_wait, rf_rdata.
// Outputs: m1t1, writeback, inc_pc, wr_sel, rd_sel, wr_en, rd_en,
//          drive_addr, rf_wdata, mem_rd, mem_wr, mem_wdata, halted.
// SEQ_ILLEGAL_TRAP_EN: adds illegal_op; undecoded opcodes halt the core.
module mcycle_sequencer
  import gb_cpu_pkg::*;
#(
  parameter int T_PER_M = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_rdata,
  input  logic       mem_wait,
  input  logic [7:0] rf_rdata,
  output logic       m1t1,
  output logic       writeback,
  output logic       inc_pc,
  output logic [2:0] wr_sel,
  output logic [2:0] rd_sel,
  output logic       wr_en,
  output logic       rd_en,
  output logic       drive_addr,
  output logic [7:0] rf_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       halted
);

  localparam int TW = $clog2(T_PER_M);

  logic          run;
  logic [2:0]    state;
  logic [7:0]    opcode;
  logic [7:0]    data_q;
  logic [7:0]    wdata_q;
  logic [TW-1:0] t_idx;
  logic          last_t;
  logic          step;
  logic          cnt_en;
  logic          t_1;
  logic          t_2;
  logic          t_12;
  logic          t_123;
  logic          t_ge3;
  dec_t          dec;
  logic [2:0]    src;
  logic [2:0]    dst;

  assign dec   = decode(opcode);
  assign src   = opcode[2:0];
  assign dst   = opcode[5:3];
  assign t_1   = (t_idx == TW'(0));
  assign t_2   = (t_idx == TW'(1));
  assign t_12  = (t_idx <= TW'(1));
  assign t_123 = (t_idx <= TW'(2));
  assign t_ge3 = (t_idx >= TW'(2));

  // run keeps every output quiet until the first
  // clock after reset, which then becomes T1.
  assign cnt_en = run && (state != ST_HALT);

  mcycle_tcounter #(
    .T_PER_M (T_PER_M),
    .TW      (TW)
  ) u_tcnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .mem_wait (mem_wait),
    .busy     (mem_rd | mem_wr),
    .t_idx    (t_idx),
    .last_t   (last_t),
    .step     (step)
  );

  assign mem_wdata = wdata_q;

  always_comb begin
    m1t1       = 1'b0;
    writeback  = 1'b0;
    inc_pc     = 1'b0;
    wr_sel     = 3'b000;
    rd_sel     = 3'b000;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    drive_addr = 1'b0;
    rf_wdata   = 8'h00;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    if (run) begin
      case (state)
        ST_FETCH: begin
          m1t1   = t_1;
          mem_rd = t_12;
          if (t_ge3 && (dec.ld_rr || dec.ld_hl_r)) begin
            rd_en  = 1'b1;
            rd_sel = src;
          end
          if (last_t && dec.ld_rr) begin
            wr_sel    = dst;
            wr_en     = 1'b1;
            writeback = 1'b1;
            rf_wdata  = rf_rdata;
          end
        end
        ST_OPERAND: begin
          mem_rd = t_12;
          inc_pc = (t_idx == TW'(2));
          if (last_t) begin
            wr_sel    = dst;
            wr_en     = 1'b1;
            writeback = 1'b1;
            rf_wdata  = data_q;
          end
        end
        ST_MEMRD: begin
          mem_rd     = t_12;
          drive_addr = t_123;
          rd_sel     = t_123 ? ADDR_HL : 3'b000;
          if (last_t) begin
            wr_sel    = dst;
            wr_en     = 1'b1;
            writeback = 1'b1;
            rf_wdata  = data_q;
          end
        end
        ST_MEMWR: begin
          drive_addr = 1'b1;
          rd_sel     = ADDR_HL;
          mem_wr     = !t_1 && t_123;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run     <= 1'b0;
      state   <= ST_FETCH;
      opcode  <= OP_NOP;
      data_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      run <= 1'b1;
      // Bus data is taken on the edge that opens T3.
      if (step && t_2) begin
        if (state == ST_FETCH)
          opcode <= mem_rdata;
        if (state == ST_OPERAND ||
            state == ST_MEMRD)
          data_q <= mem_rdata;
      end
      if (step && last_t) begin
        if (state == ST_FETCH) begin
          unique case (1'b1)
            dec.ld_d8:   state <= ST_OPERAND;
            dec.ld_r_hl: state <= ST_MEMRD;
            dec.ld_hl_r: begin
              state   <= ST_MEMWR;
              wdata_q <= rf_rdata;
            end
            dec.halt:    state <= ST_HALT;
            default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
              state <= dec.legal ?
                       ST_FETCH : ST_HALT;
`else
              state <= ST_FETCH;
`endif
            end
          endcase
        end else begin
          state <= ST_FETCH;
        end
      end
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_op <= 1'b0;
    end else if (step && last_t &&
                 state == ST_FETCH &&
                 !dec.legal) begin
      illegal_op <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb_mcycle_sequencer: randomized instruction stream checked clock by
// clock against an instruction-level reference model.
module tb_mcycle_sequencer;

  localparam int TPM = 4;

  localparam int C_NOP  = 0;
  localparam int C_RR   = 1;
  localparam int C_D8   = 2;
  localparam int C_RHL  = 3;
  localparam int C_HLR  = 4;
  localparam int C_HALT = 5;
  localparam int C_ILL  = 6;

  typedef struct packed {
    logic       m1t1;
    logic       wb;
    logic       inc;
    logic [2:0] wsel;
    logic [2:0] rsel;
    logic       wen;
    logic       ren;
    logic       daddr;
    logic [7:0] wdata;
    logic       mrd;
    logic       mwr;
    logic [7:0] mwdata;
    logic       halted;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_wait = 1'b0;
  logic [7:0] rf_rdata = 8'h00;
  logic       m1t1, writeback, inc_pc;
  logic [2:0] wr_sel, rd_sel;
  logic       wr_en, rd_en, drive_addr;
  logic [7:0] rf_wdata, mem_wdata;
  logic       mem_rd, mem_wr, halted;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  out_t obs;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_mwdata = 8'h00;

  mcycle_sequencer #(.T_PER_M(TPM)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rdata  (mem_rdata),
    .mem_wait   (mem_wait),
    .rf_rdata   (rf_rdata),
    .m1t1       (m1t1),
    .writeback  (writeback),
    .inc_pc     (inc_pc),
    .wr_sel     (wr_sel),
    .rd_sel     (rd_sel),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .drive_addr (drive_addr),
    .rf_wdata   (rf_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign obs = {m1t1, writeback, inc_pc, wr_sel,
                rd_sel, wr_en, rd_en, drive_addr,
                rf_wdata, mem_rd, mem_wr, mem_wdata,
                halted};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [7:0] op);
    int v;
    v = int'(op);
    if (v == 'h76) return C_HALT;
    if (v >= 'h40 && v <= 'h7F) begin
      if (v % 8 == 6) return C_RHL;
      if ((v / 8) % 8 == 6) return C_HLR;
      return C_RR;
    end
    if (v < 'h40 && v % 8 == 6 && v != 'h36)
      return C_D8;
    if (v == 0) return C_NOP;
    return C_ILL;
  endfunction

  function automatic int mcycles(input int cls);
    if (cls == C_D8 || cls == C_RHL || cls == C_HLR)
      return 2;
    return 1;
  endfunction

  // Expected outputs for T-state t of M-cycle m.
  function automatic out_t model(input int cls,
                                 input logic [7:0] op,
                                 input int m, input int t,
                                 input logic [7:0] rf,
                                 input logic [7:0] opnd);
    out_t e;
    logic [2:0] src;
    logic [2:0] dst;
    e = '0;
    e.mwdata = exp_mwdata;
    src = 3'(int'(op) % 8);
    dst = 3'((int'(op) / 8) % 8);
    if (m == 0) begin
      e.m1t1 = (t == 0);
      e.mrd  = (t < 2);
      if (t >= 2 && (cls == C_RR || cls == C_HLR)) begin
        e.ren  = 1'b1;
        e.rsel = src;
      end
      if (t == TPM - 1 && cls == C_RR) begin
        e.wb = 1'b1; e.wen = 1'b1;
        e.wsel = dst; e.wdata = rf;
      end
    end else if (cls == C_HLR) begin
      e.daddr = 1'b1;
      e.rsel  = 3'b110;
      e.mwr   = (t == 1 || t == 2);
    end else begin
      e.mrd = (t < 2);
      if (cls == C_D8) e.inc = (t == 2);
      if (cls == C_RHL && t < 3) begin
        e.daddr = 1'b1;
        e.rsel  = 3'b110;
      end
      if (t == TPM - 1) begin
        e.wb = 1'b1; e.wen = 1'b1;
        e.wsel = dst; e.wdata = opnd;
      end
    end
    return e;
  endfunction

  // Called at posedge+1 of T1. w1 = wait clocks in M1 T2;
  // rf_fix < 0 means random register data; stop_after < 0 runs all.
  task automatic run_instr(input logic [7:0] op,
                           input logic [7:0] opnd,
                           input int rf_fix,
                           input int w1,
                           input int stop_after);
    int cls;
    int n;
    int nw;
    cls = classify(op);
    n = 0;
    for (int m = 0; m < mcycles(cls); m++) begin
      for (int t = 0; t < TPM; t++) begin
        nw = 0;
        if (t == 1)
          nw = (m == 0) ? w1 : int'($urandom_range(0, 2));
        for (int w = 0; w <= nw; w++) begin
          if (stop_after >= 0 && n >= stop_after) return;
          mem_wait  = (t == 1) ? (w < nw) : 1'($urandom);
          mem_rdata = (t == 1) ? ((m == 0) ? op : opnd)
                               : 8'($urandom);
          rf_rdata  = (rf_fix >= 0) ? 8'(rf_fix)
                                    : 8'($urandom);
          @(negedge clk);
          chk($sformatf("op%02h_m%0d_t%0d", op, m + 1, t + 1),
              64'(obs),
              64'(model(cls, op, m, t, rf_rdata, opnd)));
          if (m == 0 && t == TPM - 1 && cls == C_HLR)
            exp_mwdata = rf_rdata;
          @(posedge clk);
          #1;
          n++;
        end
      end
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    exp_mwdata = 8'h00;
    @(negedge clk);
    chk("in_reset", 64'(obs), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_release", 64'(obs), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] op;
    out_t       eh;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 64'(obs), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_release", 64'(obs), 64'd0);
    @(posedge clk);
    #1;

    run_instr(8'h00, 8'h00, -1, 0, -1);
    run_instr(8'h00, 8'h00, -1, 0, -1);
    run_instr(8'h78, 8'h00, 'h5A, 0, -1);
    run_instr(8'h3E, 8'hC3, -1, 0, -1);
    run_instr(8'h70, 8'h00, 'h11, 0, -1);
    run_instr(8'h00, 8'h00, -1, 3, -1);
    run_instr(8'h7E, 8'h9D, -1, 1, -1);
    run_instr(8'h36, 8'hEE, -1, 0, -1);
    run_instr(8'h40, 8'h00, -1, 0, -1);

    for (int i = 0; i < 250; i++) begin
      op = 8'($urandom);
      case ($urandom_range(0, 3))
        0: op = {2'b01, op[5:0]};
        1: op = {2'b00, op[5:3], 3'b110};
        default: op = op;
      endcase
      if (op == 8'h76) op = 8'h00;
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (classify(op) == C_ILL) op = 8'h00;
`endif
      run_instr(op, 8'($urandom), -1,
                int'($urandom_range(0, 2)), -1);
    end
`ifdef SEQ_ILLEGAL_TRAP_EN
    chk("illegal_op", 64'(illegal_op), 64'd0);
`endif

    run_instr(8'h3E, 8'h55, -1, 0, 6);
    do_reset();
    run_instr(8'h00, 8'h00, -1, 0, -1);
    run_instr(8'h57, 8'h00, -1, 0, -1);

    run_instr(8'h71, 8'h00, 'hA7, 0, -1);
    run_instr(8'h76, 8'h00, -1, 0, -1);
    eh = '0;
    eh.halted = 1'b1;
    eh.mwdata = exp_mwdata;
    for (int i = 0; i < 10; i++) begin
      mem_wait  = 1'($urandom);
      mem_rdata = 8'($urandom);
      rf_rdata  = 8'($urandom);
      @(negedge clk);
      chk("halt", 64'(obs), 64'(eh));
      @(posedge clk);
      #1;
    end
    do_reset();
    run_instr(8'h00, 8'h00, -1, 0, -1);
    run_instr(8'h3E, 8'h42, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
